// File: rtl/fx2_pkg.sv
// -----------------------------------------------------------------------------
// fx2_pkg
//   Shared definitions for the FX2LP slave-FIFO playback path:
//   - flag bit positions on the FX2 FLAGN bus
//   - FIFOADR endpoint codes
//   - playback FSM state encoding
//   - pace counter terminal-count helper
// -----------------------------------------------------------------------------
package fx2_pkg;

    // Bit positions inside FLAGN (flags are active low, so a high bit means
    // "not empty" / "not full").
    localparam int FLAG_EMPTYN = 0;
    localparam int FLAG_FULLN  = 1;

    // FIFOADR codes selecting the FX2 endpoint FIFOs.
    localparam logic [1:0] FIFOADR_EP2 = 2'b00;
    localparam logic [1:0] FIFOADR_EP6 = 2'b10;

    // Width of the sample-period control word.
    localparam int RATE_W = 26;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_READ = 2'd2
    } state_t;

    // Last count value of the pace counter. 0 and 1 both mean "tick every cycle".
    function automatic logic [RATE_W-1:0] pace_last(input logic [RATE_W-1:0] rate_div);
        return (rate_div <= RATE_W'(1)) ? '0 : rate_div - RATE_W'(1);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
//   Single-clock first-word-fall-through FIFO. rd_data always shows the oldest
//   entry and is valid whenever level > 0; rd_en consumes it on the clock edge.
//   A write is accepted when there is room, or when a read frees a slot in the
//   same cycle. flush empties the FIFO and takes priority over any write.
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   flush          synchronous clear of all entries
//   wr_en/wr_data  push request and data
//   rd_en          pop request (ignored when empty)
//   rd_data        head-of-queue data
//   level          occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      level
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign do_rd   = rd_en && (level != '0) && !flush;
    assign do_wr   = wr_en && ((level != FULL_LEVEL) || do_rd) && !flush;
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and level carry
    // state that matters, so resetting the array would just cost flops.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fx2_fifo_dac_player.sv
// -----------------------------------------------------------------------------
// fx2_fifo_dac_player
//   Playback path: reads 8-bit samples from the FX2LP OUT endpoint FIFO over the
//   synchronous slave-FIFO bus into a small local buffer and paces them out to
//   the DAC every max(RATE_DIV,1) IFCLK cycles.
// Ports
//   IFCLK      sole clock (48 MHz)
//   RESET      asynchronous active-high reset
//   ENABLE     1 = fetch and play; 0 = stop, flush, drive DAC_IDLE
//   RATE_DIV   sample period in IFCLK cycles (0 and 1 = every cycle)
//   FLAGN      FX2 flags; FLAGN[0] high = OUT FIFO not empty
//   FD_IN      FX2 data bus input
//   SLRDN      FX2 read strobe (active low, combinational from FLAGN)
//   SLOEN      FX2 output enable (active low); also gates the FD pad tristate
//   SLWRN      tied inactive
//   PKTENDN    tied inactive
//   FIFOADR    endpoint select, tied to FIFO_ADDR
//   DAC_DATA   registered DAC code
//   LEVEL      local buffer occupancy
//   UNDERRUNS  saturating count of sample ticks that found the buffer empty
// -----------------------------------------------------------------------------
module fx2_fifo_dac_player
    import fx2_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter logic [1:0] FIFO_ADDR = FIFOADR_EP6,
    parameter logic [7:0] DAC_IDLE  = 8'h80
) (
    input  logic                     IFCLK,
    input  logic                     RESET,
    input  logic                     ENABLE,
    input  logic [RATE_W-1:0]        RATE_DIV,
    input  logic [2:0]               FLAGN,
    input  logic [7:0]               FD_IN,
    output logic                     SLRDN,
    output logic                     SLOEN,
    output logic                     SLWRN,
    output logic                     PKTENDN,
    output logic [1:0]               FIFOADR,
    output logic [7:0]               DAC_DATA,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic [15:0]              UNDERRUNS
);

    localparam int          LW         = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    state_t            state;
    logic [RATE_W-1:0] pace_cnt;
    logic              tick;
    logic              pop;
    logic              capture;
    logic [7:0]        head_data;
    logic              unused_flags;

    assign SLWRN   = 1'b1;
    assign PKTENDN = 1'b1;
    assign FIFOADR = FIFO_ADDR;

    // Only the other FX2 flags are ignored; the full flag belongs to the IN path.
    assign unused_flags = &{1'b0, FLAGN[FLAG_FULLN], FLAGN[2]};

    // Read strobe is the one combinational path from FLAGN: the FX2 presents
    // the byte while SLRDN is low and it is captured on that same edge, so no
    // speculative read ever has to be undone.
    assign capture = (state == ST_READ) && FLAGN[FLAG_EMPTYN] && (LEVEL != FULL_LEVEL);
    assign SLRDN   = ~capture;

    assign tick = ENABLE && (pace_cnt == '0);
    assign pop  = tick && (LEVEL != '0);

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_buf (
        .clk     (IFCLK),
        .rst     (RESET),
        .flush   (!ENABLE),
        .wr_en   (capture),
        .wr_data (FD_IN),
        .rd_en   (tick),
        .rd_data (head_data),
        .level   (LEVEL)
    );

    // Bus FSM. ARM holds SLOEN low for one cycle before any read so the FD pad
    // has turned around before the FX2 starts driving data.
    always_ff @(posedge IFCLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
            SLOEN <= 1'b1;
        end else if (!ENABLE) begin
            state <= ST_IDLE;
            SLOEN <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_ARM;
                    SLOEN <= 1'b0;
                end
                ST_ARM: begin
                    state <= ST_READ;
                    SLOEN <= 1'b0;
                end
                ST_READ: begin
                    state <= ST_READ;
                    SLOEN <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    SLOEN <= 1'b1;
                end
            endcase
        end
    end

    // Pace counter. Comparing with ">=" makes a shrinking RATE_DIV that lands
    // below the current count wrap to 0 on the next cycle.
    always_ff @(posedge IFCLK or posedge RESET) begin
        if (RESET) begin
            pace_cnt <= '0;
        end else if (!ENABLE || (pace_cnt >= pace_last(RATE_DIV))) begin
            pace_cnt <= '0;
        end else begin
            pace_cnt <= pace_cnt + 1'b1;
        end
    end

    // DAC output and underrun statistics. UNDERRUNS survives ENABLE=0.
    always_ff @(posedge IFCLK or posedge RESET) begin
        if (RESET) begin
            DAC_DATA  <= DAC_IDLE;
            UNDERRUNS <= '0;
        end else begin
            if (!ENABLE) begin
                DAC_DATA <= DAC_IDLE;
            end else if (pop) begin
                DAC_DATA <= head_data;
            end
            if (tick && (LEVEL == '0) && (UNDERRUNS != 16'hFFFF)) begin
                UNDERRUNS <= UNDERRUNS + 1'b1;
            end
        end
    end

endmodule
